usb_fs_tx: RTL and testbench



---
 rtl/usb_fs_tx_if.sv | 32 +++
 rtl/usb_fs_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_usb_fs_tx.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_fs_tx_if.sv
// usb_fs_tx_if: application-side bundle for the full-speed USB transmitter.
//   pkt_start   request to send a packet (one cycle)
//   pid         PID nibble, captured with an accepted pkt_start
//   data        payload byte, consumed when data_strobe is high
//   data_valid  payload byte available; low at a byte boundary ends payload
//   data_strobe transmitter consumed data this cycle
//   busy        packet in progress
//   tx_en       line driver enable
//   tx_j        line state, 1=J 0=K (when tx_se0=0)
//   tx_se0      drive SE0
// master: packet source / line observer; slave: the transmitter.
interface usb_fs_tx_if;
    logic       pkt_start;
    logic [3:0] pid;
    logic [7:0] data;
    logic       data_valid;
    logic       data_strobe;
    logic       busy;
    logic       tx_en;
    logic       tx_j;
    logic       tx_se0;

    modport master (
        output pkt_start, pid, data, data_valid,
        input  data_strobe, busy, tx_en, tx_j, tx_se0
    );

    modport slave (
        input  pkt_start, pid, data, data_valid,
        output data_strobe, busy, tx_en, tx_j, tx_se0
    );
endinterface

// File: rtl/usb_fs_tx.sv
// usb_fs_tx: full-speed (12 Mb/s) USB packet serializer.
// Emits SYNC, PID, optional payload + CRC16, bit stuffing, NRZI and EOP.
//   clk48mhz  48 MHz system clock
//   rst       synchronous reset, active-low
//   bus       usb_fs_tx_if.slave (packet request, payload feed, line outputs)
// Parameters:
//   BIT_CLKS   clock cycles per bit period
//   MAX_BYTES  payload limit; CRC follows automatically once reached
module usb_fs_tx #(
    parameter int unsigned BIT_CLKS  = 4,
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic        clk48mhz,
    input  logic        rst,
    usb_fs_tx_if.slave  bus
);

    localparam int unsigned PW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(BIT_CLKS - 1);
    localparam logic [6:0]    MAXB       = 7'(MAX_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP_SE0,
        ST_EOP_J
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [7:0]    shreg, shreg_n;     // current field, bit on the line at [0]
    logic [2:0]    bit_cnt, bit_cnt_n; // bit within field / EOP period count
    logic [2:0]    ones_cnt, ones_n;
    logic [15:0]   crc, crc_n;         // reflected CRC16 register
    logic [6:0]    byte_cnt, byte_cnt_n;
    logic [3:0]    pid_lat, pid_n;
    logic          line_j, tx_j_n;
    logic          line_se0, tx_se0_n;
    logic          line_en, tx_en_n;
    logic          busy_reg, busy_n;

    logic          tick;
    logic          strobe;
    logic          data_bnd;
    logic          eop;
    logic          load;
    logic [7:0]    ld_val;
    logic          snd;
    logic          snd_bit;

    // Reflected form of polynomial 0x8005 (0xA001), LSB-first data. Sending
    // the complemented register low byte first, LSB first, matches the
    // bit-serial CRC over the payload bits.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 16'hA001 : 16'h0000);
        end
        return r;
    endfunction

    always_ff @(posedge clk48mhz) begin
        if (!rst) begin
            state    <= ST_IDLE;
            phase    <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            ones_cnt <= '0;
            crc      <= '1;
            byte_cnt <= '0;
            pid_lat  <= '0;
            line_j   <= 1'b1;
            line_se0 <= 1'b0;
            line_en  <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            ones_cnt <= ones_n;
            crc      <= crc_n;
            byte_cnt <= byte_cnt_n;
            pid_lat  <= pid_n;
            line_j   <= tx_j_n;
            line_se0 <= tx_se0_n;
            line_en  <= tx_en_n;
            busy_reg <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        ones_n     = ones_cnt;
        crc_n      = crc;
        byte_cnt_n = byte_cnt;
        pid_n      = pid_lat;
        tx_j_n     = line_j;
        tx_se0_n   = line_se0;
        tx_en_n    = line_en;
        busy_n     = busy_reg;
        strobe     = 1'b0;
        data_bnd   = 1'b0;
        eop        = 1'b0;
        load       = 1'b0;
        ld_val     = '0;
        snd        = 1'b0;
        snd_bit    = 1'b0;

        tick = (phase == PHASE_LAST);
        if (state != ST_IDLE) begin
            phase_n = tick ? '0 : phase + PW'(1);
        end

        case (state)
            ST_IDLE: begin
                if (bus.pkt_start) begin
                    state_n    = ST_SYNC;
                    pid_n      = bus.pid;
                    busy_n     = 1'b1;
                    tx_en_n    = 1'b1;
                    bit_cnt_n  = '0;
                    byte_cnt_n = '0;
                    crc_n      = '1;
                    // First SYNC bit goes out at this same edge.
                    load       = 1'b1;
                    ld_val     = 8'h80;
                end
            end

            ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI: begin
                if (tick) begin
                    if (ones_cnt == 3'd6) begin
                        // Stuff bit: holds the field position, so a stuff
                        // after the last bit of a field delays the boundary.
                        tx_j_n = ~line_j;
                        ones_n = '0;
                    end else if (bit_cnt != 3'd7) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        shreg_n   = shreg >> 1;
                        snd       = 1'b1;
                        snd_bit   = shreg[1];
                    end else begin
                        bit_cnt_n = '0;
                        case (state)
                            ST_SYNC: begin
                                state_n = ST_PID;
                                load    = 1'b1;
                                ld_val  = {~pid_lat, pid_lat};
                            end
                            ST_PID: begin
                                if (pid_lat[1:0] == 2'b11) data_bnd = 1'b1;
                                else                       eop      = 1'b1;
                            end
                            ST_DATA: data_bnd = 1'b1;
                            ST_CRC_LO: begin
                                state_n = ST_CRC_HI;
                                load    = 1'b1;
                                ld_val  = ~crc[15:8];
                            end
                            default: eop = 1'b1;
                        endcase
                    end
                end
            end

            ST_EOP_SE0: begin
                if (tick) begin
                    if (bit_cnt == 3'd1) begin
                        state_n  = ST_EOP_J;
                        tx_se0_n = 1'b0;
                        tx_j_n   = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end

            ST_EOP_J: begin
                if (tick) begin
                    state_n = ST_IDLE;
                    tx_en_n = 1'b0;
                    busy_n  = 1'b0;
                    tx_j_n  = 1'b1;
                end
            end

            default: state_n = ST_IDLE;
        endcase

        // Byte boundary in the payload phase: take another byte or close with CRC.
        if (data_bnd) begin
            if (bus.data_valid && (byte_cnt < MAXB)) begin
                strobe     = 1'b1;
                state_n    = ST_DATA;
                load       = 1'b1;
                ld_val     = bus.data;
                crc_n      = crc16_byte(crc, bus.data);
                byte_cnt_n = byte_cnt + 7'd1;
            end else begin
                state_n = ST_CRC_LO;
                load    = 1'b1;
                ld_val  = ~crc[7:0];
            end
        end

        if (eop) begin
            state_n   = ST_EOP_SE0;
            tx_se0_n  = 1'b1;
            bit_cnt_n = '0;
        end

        if (load) begin
            shreg_n = ld_val;
            snd     = 1'b1;
            snd_bit = ld_val[0];
        end

        // NRZI: 0 toggles, 1 holds; track run of ones for stuffing.
        if (snd) begin
            tx_j_n = snd_bit ? line_j : ~line_j;
            ones_n = snd_bit ? ones_cnt + 3'd1 : '0;
        end
    end

    assign bus.data_strobe = rst & strobe;
    assign bus.busy        = busy_reg;
    assign bus.tx_en       = line_en;
    assign bus.tx_j        = line_j;
    assign bus.tx_se0      = line_se0;

endmodule

// File: tb/tb_usb_fs_tx.sv
module tb_usb_fs_tx;

    localparam int unsigned BIT  = 4;
    localparam int unsigned MAXB = 64;

    logic clk48mhz = 1'b0;
    logic rst;
    always #10 clk48mhz = ~clk48mhz;

    usb_fs_tx_if bus();

    usb_fs_tx #(.BIT_CLKS(BIT), .MAX_BYTES(MAXB)) dut (
        .clk48mhz (clk48mhz),
        .rst      (rst),
        .bus      (bus.slave)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0]  exp_q[$];   // expected decoded bytes after SYNC
    logic [1:0]  sym_q[$];   // per-cycle line symbols: 10=SE0, 01=J, 00=K
    logic        discard = 1'b0;
    int unsigned pkt_cnt = 0;

    int unsigned feed_n = 0;
    int unsigned feed_idx = 0;
    logic [7:0]  feed_start = '0;
    logic [7:0]  feed_step = '0;
    int unsigned stb_cnt = 0;

    typedef struct {
        logic [3:0]  pid;
        int unsigned n_avail;
        logic [7:0]  start;
        logic [7:0]  step;
        int unsigned exp_stb;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Forward (MSB-register) CRC16, poly 0x8005, data LSB first.
    function automatic logic [15:0] crc_fwd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if ((d[i] ^ r[15]) == 1'b1) r = {r[14:0], 1'b0} ^ 16'h8005;
            else                        r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Payload feeder: advances after each consumed byte.
    initial begin
        logic s;
        bus.data = '0;
        bus.data_valid = 1'b0;
        forever begin
            @(negedge clk48mhz);
            s = bus.data_strobe;
            @(posedge clk48mhz);
            #1;
            if (s) begin
                stb_cnt++;
                feed_idx++;
            end
            bus.data_valid = (feed_idx < feed_n);
            bus.data = 8'(feed_start + 8'(feed_idx) * feed_step);
        end
    end

    // Decode one finished packet and compare against the scoreboard.
    task automatic check_packet();
        int unsigned n, nper, ones, bitn;
        logic ok_t, b, stuff_err;
        logic [1:0] s, prev;
        logic [7:0] acc, e;
        logic [7:0] got[$];
        logic [15:0] c;
        n = sym_q.size();
        ok_t = (n % BIT == 0) && (n >= 3 * BIT);
        if (ok_t) begin
            for (int p = 0; p < int'(n / BIT); p++)
                for (int k = 1; k < int'(BIT); k++)
                    if (sym_q[p*BIT+k] != sym_q[p*BIT]) ok_t = 1'b0;
        end
        chk("bit_timing", 32'(ok_t), 32'd1);
        if (!ok_t) begin
            exp_q.delete();
            return;
        end
        nper = n / BIT;
        chk("eop", 32'({sym_q[(nper-3)*BIT], sym_q[(nper-2)*BIT], sym_q[(nper-1)*BIT]}),
            32'(6'b10_10_01));
        prev = 2'b01; ones = 0; bitn = 0; acc = '0; stuff_err = 1'b0;
        for (int p = 0; p < int'(nper) - 3; p++) begin
            s = sym_q[p*BIT];
            if (s == 2'b10) stuff_err = 1'b1;
            b = (s == prev);
            prev = s;
            if (ones == 6) begin
                if (b) stuff_err = 1'b1;
                ones = 0;
            end else begin
                ones = b ? ones + 1 : 0;
                acc[bitn] = b;
                bitn++;
                if (bitn == 8) begin
                    got.push_back(acc);
                    bitn = 0;
                end
            end
        end
        if (ones == 6) stuff_err = 1'b1;
        chk("stuffing", 32'({stuff_err, bitn == 0}), 32'd1);
        if (got.size() == 0) got.push_back(8'h00);
        chk("sync", 32'(got[0]), 32'h80);
        for (int k = 1; k < got.size(); k++) begin
            if (exp_q.size() == 0) begin
                chk("extra_byte", 32'(got[k]), 32'h100);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("byte%0d", k), 32'(got[k]), 32'(e));
            end
        end
        chk("missing_bytes", exp_q.size(), 0);
        exp_q.delete();
        if (got.size() >= 4 && got[1][1:0] == 2'b11) begin
            c = 16'hFFFF;
            for (int k = 2; k < got.size(); k++) c = crc_fwd(c, got[k]);
            chk("crc_residual", 32'(c), 32'h800D);
        end
    endtask

    // Line monitor.
    initial begin
        logic inp;
        inp = 1'b0;
        forever begin
            @(negedge clk48mhz);
            if (bus.tx_en) begin
                sym_q.push_back(bus.tx_se0 ? 2'b10 : {1'b0, bus.tx_j});
                inp = 1'b1;
            end else if (inp) begin
                inp = 1'b0;
                if (!discard) check_packet();
                sym_q.delete();
                pkt_cnt++;
            end
        end
    end

    task automatic run_pkt(input logic [3:0] p, input int unsigned n, input logic [7:0] st,
                           input logic [7:0] sp, input int unsigned exp_stb,
                           input int unsigned poke, input string nm);
        logic [7:0] wb[$];
        logic [7:0] v;
        logic [15:0] c;
        int unsigned np, ones, stf, cyc, exp_cyc;
        logic done;
        np = (p[1:0] == 2'b11) ? ((n < MAXB) ? n : MAXB) : 0;
        wb.push_back(8'h80);
        wb.push_back({~p, p});
        c = 16'hFFFF;
        for (int unsigned i = 0; i < np; i++) begin
            v = 8'(st + 8'(i) * sp);
            wb.push_back(v);
            c = crc_fwd(c, v);
        end
        if (p[1:0] == 2'b11) begin
            wb.push_back(rev8(~c[15:8]));
            wb.push_back(rev8(~c[7:0]));
        end
        for (int k = 1; k < wb.size(); k++) exp_q.push_back(wb[k]);
        ones = 0; stf = 0;
        foreach (wb[k]) begin
            v = wb[k];
            for (int j = 0; j < 8; j++) begin
                if (v[j]) begin
                    ones++;
                    if (ones == 6) begin stf++; ones = 0; end
                end else ones = 0;
            end
        end
        exp_cyc = (8 * wb.size() + stf + 3) * BIT + 1;

        feed_n = n; feed_start = st; feed_step = sp; feed_idx = 0; stb_cnt = 0;
        @(posedge clk48mhz); #1;
        bus.pid = p;
        bus.pkt_start = 1'b1;
        cyc = 0; done = 1'b0;
        while (!done && cyc < 6000) begin
            @(posedge clk48mhz); #1;
            cyc++;
            if (cyc == 1) begin
                bus.pkt_start = 1'b0;
                chk({nm, "_latency_en"}, 32'(bus.tx_en), 32'd1);
                chk({nm, "_latency_busy"}, 32'(bus.busy), 32'd1);
            end
            if (poke != 0 && cyc == poke)     bus.pkt_start = 1'b1;
            if (poke != 0 && cyc == poke + 1) bus.pkt_start = 1'b0;
            if (!bus.busy) done = 1'b1;
        end
        chk({nm, "_cycles"}, cyc, exp_cyc);
        chk({nm, "_en_off"}, 32'(bus.tx_en), 32'd0);
        chk({nm, "_strobes"}, stb_cnt, exp_stb);
        feed_n = 0;
        repeat (6) @(posedge clk48mhz);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_tx_en"}, 32'(bus.tx_en), 32'd0);
        chk({nm, "_tx_j"}, 32'(bus.tx_j), 32'd1);
        chk({nm, "_tx_se0"}, 32'(bus.tx_se0), 32'd0);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_strobe"}, 32'(bus.data_strobe), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned cnt0, cyc;
        tbl[0] = '{pid: 4'b0010, n_avail: 0,  start: 8'h00, step: 8'h00, exp_stb: 0};  // ACK
        tbl[1] = '{pid: 4'b1011, n_avail: 0,  start: 8'h00, step: 8'h00, exp_stb: 0};  // DATA1 empty
        tbl[2] = '{pid: 4'b0011, n_avail: 2,  start: 8'hFF, step: 8'h00, exp_stb: 2};  // DATA0 FF FF
        tbl[3] = '{pid: 4'b0011, n_avail: 70, start: 8'h00, step: 8'h01, exp_stb: 64}; // limit
        tbl[4] = '{pid: 4'b1010, n_avail: 3,  start: 8'h55, step: 8'h01, exp_stb: 0};  // NAK ignores data
        tbl[5] = '{pid: 4'b1011, n_avail: 4,  start: 8'h00, step: 8'h01, exp_stb: 4};  // DATA1 00..03
        tbl[6] = '{pid: 4'b1110, n_avail: 0,  start: 8'h00, step: 8'h00, exp_stb: 0};  // STALL
        tbl[7] = '{pid: 4'b0011, n_avail: 5,  start: 8'hA5, step: 8'h11, exp_stb: 5};

        bus.pkt_start = 1'b0;
        bus.pid = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk48mhz);
        #1;
        chk_idle("reset");
        rst = 1'b1;
        repeat (2) @(posedge clk48mhz);
        #1;

        for (int i = 0; i < 8; i++)
            run_pkt(tbl[i].pid, tbl[i].n_avail, tbl[i].start, tbl[i].step,
                    tbl[i].exp_stb, 0, $sformatf("vec%0d", i));

        // pkt_start while busy must be ignored.
        cnt0 = pkt_cnt;
        run_pkt(4'b0010, 0, 8'h00, 8'h00, 0, 20, "poke");
        repeat (100) @(posedge clk48mhz);
        #1;
        chk("poke_pkt_count", pkt_cnt, cnt0 + 1);
        chk("poke_idle_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of payload byte 3.
        feed_n = 10; feed_start = 8'h10; feed_step = 8'h01; feed_idx = 0; stb_cnt = 0;
        @(posedge clk48mhz); #1;
        bus.pid = 4'b0011;
        bus.pkt_start = 1'b1;
        @(posedge clk48mhz); #1;
        bus.pkt_start = 1'b0;
        cyc = 0;
        while (stb_cnt < 3 && cyc < 1000) begin
            @(posedge clk48mhz); #1;
            cyc++;
        end
        chk("abort_reached_byte3", 32'(stb_cnt >= 3), 32'd1);
        repeat (10) @(posedge clk48mhz);
        #1;
        chk("abort_pre_busy", 32'(bus.busy), 32'd1);
        discard = 1'b1;
        rst = 1'b0;
        @(posedge clk48mhz); #1;
        chk_idle("abort");
        @(posedge clk48mhz); #1;
        rst = 1'b1;
        exp_q.delete();
        feed_n = 0;
        repeat (4) @(posedge clk48mhz);
        #1;
        discard = 1'b0;
        run_pkt(4'b0010, 0, 8'h00, 8'h00, 0, 0, "post_reset_ack");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
